crossing_detector: RTL and testbench

Upstream control stage for the turkey counter datapath. It watches the left and right beam sensors, runs a direction state machine that recognises complete left-to-right and right-to-left crossings, and emits one-cycle `inc`/`dec` pulses for the turkey up/down counter. It also generates the `CE`/`R` pair that drives the downstream seconds timer: 1 s enables derived from the quarter-second tick, and a timer clear on every completed crossing.

---
 rtl/crossing_detector.sv | 165 ++++++++++++++++
 tb/tb_crossing_detector.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crossing_detector.sv
`default_nettype none
// ============================================================================
// Module  : crossing_detector
// Brief   : Beam-sensor direction FSM emitting inc/dec pulses, plus the
//           seconds-timer enable/clear pair derived from the qsec tick.
// Rev     : 1.0  initial release
// ============================================================================
module crossing_detector #(
  parameter int TICKS_PER_SEC = 4
) (
  input  logic       clk,
  input  logic       R,
  input  logic       sL,
  input  logic       sR,
  input  logic       qsec,
  output logic       inc,
  output logic       dec,
  output logic       time_ce,
  output logic       time_r,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L1   = 3'd1,
    S_LB   = 3'd2,
    S_L2   = 3'd3,
    S_R1   = 3'd4,
    S_RB   = 3'd5,
    S_R2   = 3'd6
  } state_t;

  localparam logic [3:0] c_LAST_TICK = 4'(TICKS_PER_SEC - 1);

  logic [1:0] r_sync_l;
  logic [1:0] r_sync_r;
  logic [1:0] w_s;
  logic       w_done;
  state_t     r_state;
  logic       r_inc;
  logic       r_dec;
  logic       r_time_ce;
  logic       r_time_r;
  logic [3:0] r_qcnt;

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_sync_l <= 2'b00;
      r_sync_r <= 2'b00;
    end else begin
      r_sync_l <= {r_sync_l[0], sL};
      r_sync_r <= {r_sync_r[0], sR};
    end
  end

  assign w_s    = {r_sync_l[1], r_sync_r[1]};
  // A crossing completes when the exit-side beam clears from L2/R2.
  assign w_done = ((r_state == S_L2) || (r_state == S_R2)) && (w_s == 2'b00);

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_state  <= S_IDLE;
      r_inc    <= 1'b0;
      r_dec    <= 1'b0;
      r_time_r <= 1'b0;
    end else begin
      r_inc    <= 1'b0;
      r_dec    <= 1'b0;
      r_time_r <= w_done;
      case (r_state)
        S_IDLE: begin
          case (w_s)
            2'b10:   r_state <= S_L1;
            2'b01:   r_state <= S_R1;
            default: r_state <= S_IDLE;
          endcase
        end
        S_L1: begin
          case (w_s)
            2'b10:   r_state <= S_L1;
            2'b11:   r_state <= S_LB;
            default: r_state <= S_IDLE;
          endcase
        end
        S_LB: begin
          case (w_s)
            2'b11:   r_state <= S_LB;
            2'b10:   r_state <= S_L1;
            2'b01:   r_state <= S_L2;
            default: r_state <= S_IDLE;
          endcase
        end
        S_L2: begin
          case (w_s)
            2'b01:   r_state <= S_L2;
            2'b11:   r_state <= S_LB;
            2'b00: begin
              r_state <= S_IDLE;
              r_inc   <= 1'b1;
            end
            default: r_state <= S_IDLE;
          endcase
        end
        S_R1: begin
          case (w_s)
            2'b01:   r_state <= S_R1;
            2'b11:   r_state <= S_RB;
            default: r_state <= S_IDLE;
          endcase
        end
        S_RB: begin
          case (w_s)
            2'b11:   r_state <= S_RB;
            2'b01:   r_state <= S_R1;
            2'b10:   r_state <= S_R2;
            default: r_state <= S_IDLE;
          endcase
        end
        S_R2: begin
          case (w_s)
            2'b10:   r_state <= S_R2;
            2'b11:   r_state <= S_RB;
            2'b00: begin
              r_state <= S_IDLE;
              r_dec   <= 1'b1;
            end
            default: r_state <= S_IDLE;
          endcase
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Restarting the prescaler on a crossing makes the first second a full one.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_qcnt    <= 4'd0;
      r_time_ce <= 1'b0;
    end else if (w_done) begin
      r_qcnt    <= 4'd0;
      r_time_ce <= 1'b0;
    end else if (qsec) begin
      if (r_qcnt == c_LAST_TICK) begin
        r_qcnt    <= 4'd0;
        r_time_ce <= 1'b1;
      end else begin
        r_qcnt    <= r_qcnt + 4'd1;
        r_time_ce <= 1'b0;
      end
    end else begin
      r_time_ce <= 1'b0;
    end
  end

  assign inc     = r_inc;
  assign dec     = r_dec;
  assign time_ce = r_time_ce;
  assign time_r  = r_time_r;
  assign busy    = (r_state != S_IDLE);
  assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_crossing_detector.sv
`default_nettype none
// ============================================================================
// Module  : tb_crossing_detector
// Brief   : Directed self-checking bench for crossing_detector.
// Rev     : 1.0  initial release
// ============================================================================
module tb_crossing_detector;

  logic       clk = 1'b0;
  logic       R = 1'b0;
  logic       sL = 1'b0;
  logic       sR = 1'b0;
  logic       qsec = 1'b0;
  logic       inc;
  logic       dec;
  logic       time_ce;
  logic       time_r;
  logic       busy;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  crossing_detector #(.TICKS_PER_SEC(4)) dut (
    .clk     (clk),
    .R       (R),
    .sL      (sL),
    .sR      (sR),
    .qsec    (qsec),
    .inc     (inc),
    .dec     (dec),
    .time_ce (time_ce),
    .time_r  (time_r),
    .busy    (busy),
    .state   (state)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    R = 1'b0; sL = 1'b0; sR = 1'b0; qsec = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({inc, dec, time_ce, time_r, busy, state} !== 8'd0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: outputs=%b expected 00000000", i,
                 {inc, dec, time_ce, time_r, busy, state});
      end
      qsec = ~qsec;
    end
    qsec = 1'b0;
    R = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({inc, dec, time_ce, time_r, busy, state} !== 8'd0) begin
        errors++;
        $display("FAIL reset_release cyc %0d: outputs=%b expected 00000000", i,
                 {inc, dec, time_ce, time_r, busy, state});
      end
    end
  endtask

  // Sensors change every 5 cycles; inputs applied at negedge, sampled next negedge.
  task automatic test_l2r();
    logic [1:0] seq [4];
    logic [2:0] st [20];
    int n_inc;
    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    st  = '{0,0,1,1,1, 1,1,2,2,2, 2,2,3,3,3, 3,3,0,0,0};
    n_inc = 0;
    for (int i = 0; i < 20; i++) begin
      {sL, sR} = seq[i/5];
      @(negedge clk);
      checks++;
      if (state !== st[i] || busy !== (st[i] != 3'd0)) begin
        errors++;
        $display("FAIL l2r_state cyc %0d: state=%0d busy=%b expected state=%0d", i, state, busy, st[i]);
      end
      checks++;
      if ({inc, dec, time_r} !== ((i == 17) ? 3'b101 : 3'b000)) begin
        errors++;
        $display("FAIL l2r_pulse cyc %0d: inc,dec,time_r=%b expected %b", i, {inc, dec, time_r},
                 (i == 17) ? 3'b101 : 3'b000);
      end
      if (inc === 1'b1) n_inc++;
    end
    checks++;
    if (n_inc !== 1) begin
      errors++;
      $display("FAIL l2r_count: inc pulses=%0d expected 1", n_inc);
    end
  endtask

  task automatic test_r2l_backout();
    logic [1:0] seq [8];
    logic [2:0] st [40];
    int n_dec;
    seq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11, 2'b10, 2'b00};
    st  = '{0,0,4,4,4, 4,4,5,5,5, 5,5,6,6,6, 6,6,0,0,0,
            0,0,1,1,1, 1,1,2,2,2, 2,2,1,1,1, 1,1,0,0,0};
    n_dec = 0;
    for (int i = 0; i < 40; i++) begin
      {sL, sR} = seq[i/5];
      @(negedge clk);
      checks++;
      if (state !== st[i] || busy !== (st[i] != 3'd0)) begin
        errors++;
        $display("FAIL r2l_state cyc %0d: state=%0d busy=%b expected state=%0d", i, state, busy, st[i]);
      end
      checks++;
      if ({inc, dec, time_r} !== ((i == 17) ? 3'b011 : 3'b000)) begin
        errors++;
        $display("FAIL r2l_pulse cyc %0d: inc,dec,time_r=%b expected %b", i, {inc, dec, time_r},
                 (i == 17) ? 3'b011 : 3'b000);
      end
      if (dec === 1'b1) n_dec++;
    end
    checks++;
    if (n_dec !== 1) begin
      errors++;
      $display("FAIL r2l_count: dec pulses=%0d expected 1", n_dec);
    end
  endtask

  // L1 -> IDLE on the illegal jump; the still-blocked right beam then starts R1.
  task automatic test_illegal();
    logic [1:0] seq [3];
    logic [2:0] st [15];
    seq = '{2'b10, 2'b01, 2'b00};
    st  = '{0,0,1,1,1, 1,1,0,4,4, 4,4,0,0,0};
    for (int i = 0; i < 15; i++) begin
      {sL, sR} = seq[i/5];
      @(negedge clk);
      checks++;
      if (state !== st[i] || {inc, dec, time_r} !== 3'b000) begin
        errors++;
        $display("FAIL illegal cyc %0d: state=%0d inc,dec,time_r=%b expected state=%0d 000", i,
                 state, {inc, dec, time_r}, st[i]);
      end
    end
  endtask

  task automatic test_prescaler();
    int n_ce;
    n_ce = 0;
    {sL, sR} = 2'b00;
    for (int p = 1; p <= 12; p++) begin
      qsec = 1'b1;
      @(negedge clk);
      qsec = 1'b0;
      checks++;
      if (time_ce !== ((p % 4) == 0)) begin
        errors++;
        $display("FAIL prescaler qsec %0d: time_ce=%b expected %b", p, time_ce, (p % 4) == 0);
      end
      if (time_ce === 1'b1) n_ce++;
      for (int c = 0; c < 9; c++) begin
        @(negedge clk);
        if (time_ce === 1'b1) n_ce++;
      end
    end
    checks++;
    if (n_ce !== 3) begin
      errors++;
      $display("FAIL prescaler_count: time_ce pulses=%0d expected 3", n_ce);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] seq [4];
    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    for (int p = 1; p <= 3; p++) begin
      qsec = 1'b1;
      @(negedge clk);
      qsec = 1'b0;
      checks++;
      if (time_ce !== 1'b0) begin
        errors++;
        $display("FAIL simul_pre qsec %0d: time_ce=%b expected 0", p, time_ce);
      end
      repeat (3) @(negedge clk);
    end
    // Fourth qsec lands on the crossing-completion edge.
    for (int i = 0; i < 20; i++) begin
      {sL, sR} = seq[i/5];
      qsec = (i == 17);
      @(negedge clk);
      if (i == 17) begin
        checks++;
        if ({inc, time_r, time_ce} !== 3'b110) begin
          errors++;
          $display("FAIL simul_edge: inc,time_r,time_ce=%b expected 110", {inc, time_r, time_ce});
        end
      end
    end
    qsec = 1'b0;
    for (int p = 1; p <= 4; p++) begin
      qsec = 1'b1;
      @(negedge clk);
      qsec = 1'b0;
      checks++;
      if (time_ce !== (p == 4)) begin
        errors++;
        $display("FAIL simul_post qsec %0d: time_ce=%b expected %b", p, time_ce, p == 4);
      end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_reset_in_lb();
    {sL, sR} = 2'b10;
    repeat (5) @(negedge clk);
    {sL, sR} = 2'b11;
    repeat (5) @(negedge clk);
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL lb_reach: state=%0d expected 2", state);
    end
    #2;
    R = 1'b0;
    {sL, sR} = 2'b00;
    #1;
    checks++;
    if (state !== 3'd0 || busy !== 1'b0 || {inc, dec, time_r, time_ce} !== 4'b0000) begin
      errors++;
      $display("FAIL lb_async_reset: state=%0d busy=%b pulses=%b expected 0 0 0000", state, busy,
               {inc, dec, time_r, time_ce});
    end
    @(negedge clk);
    R = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (state !== 3'd0 || {inc, dec, time_r} !== 3'b000) begin
        errors++;
        $display("FAIL lb_after_reset cyc %0d: state=%0d inc,dec,time_r=%b expected 0 000", i,
                 state, {inc, dec, time_r});
      end
    end
  endtask

  initial begin
    test_reset();
    test_l2r();
    test_r2l_backout();
    test_illegal();
    test_prescaler();
    test_simultaneous();
    test_reset_in_lb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
